pit_data_reader: RTL and testbench
==================================

Name: pit_data_reader

Overview:
- Read-side companion to the PIT hash table in the NDN router.
- When the PIT returns a hit for a Data packet (valid bit [63] and pending bit [62] both set), this block captures the entry's 62-bit buffer base address and reads the entry's 1024-byte data block from buffer memory.
- It streams the block to the egress face over a valid/ready handshake, then requests release of the PIT hash slot so the entry can be cleared.

Parameters:
- ADDR_W, 62: buffer byte-address width; equals PIT entry address field [61:0].
- MEM_W, 64: buffer memory read-word width in bits (8 bytes).
- BLOCK_BYTES, 1024: bytes per PIT data block; must equal the PIT allocation stride.
- WORDS, 128: BLOCK_BYTES*8/MEM_W; words per block.
- HASH_W, 10: PIT slot index width.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: reset, synchronous, active-low (rst==0 resets on the next clk edge).
- table_entry, input, 64: PIT entry. [63] = valid, [62] = pending, [61:0] = buffer base byte address.
- pit_in_bit, input, 1: strobe; table_entry and entry_hash are valid this cycle.
- entry_hash, input, HASH_W: PIT slot index of table_entry.
- mem_rd_en, output, 1: buffer read request.
- mem_rd_addr, output, ADDR_W: read byte address.
- mem_rd_data, input, MEM_W: read data, valid exactly 1 cycle after mem_rd_en.
- out_data, output, MEM_W: egress data word.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: egress accepts the word.
- out_last, output, 1: high together with the final word of the block.
- release_valid, output, 1: request to clear the PIT slot.
- release_hash, output, HASH_W: slot to clear.
- release_ack, input, 1: PIT has accepted the release.
- busy, output, 1: high in every state except IDLE.
- dropped, output, 1: one-cycle pulse when an acceptable entry is refused.

Behaviour:
- Reset values: all outputs 0; state IDLE; word_idx 0; internal base/hash registers 0. A reset mid-operation abandons the block immediately: no release is issued, and in-flight mem_rd_data is discarded.
- States: IDLE, FETCH, CAPTURE, SEND, RELEASE.
- IDLE:
  - If pit_in_bit && table_entry[63] && table_entry[62]: latch base = table_entry[61:0] and hash = entry_hash; set word_idx = 0; go to FETCH.
  - If pit_in_bit with [63]==0 or [62]==0 (miss, or interest allocation): ignore, no dropped pulse.
- FETCH (1 cycle):
  - mem_rd_en = 1.
  - mem_rd_addr = (base + 8*word_idx) mod 2^ADDR_W; wraps silently, no alignment forced.
  - Next state CAPTURE.
- CAPTURE (1 cycle):
  - mem_rd_en = 0.
  - At the edge, out_data <= mem_rd_data; out_valid <= 1; out_last <= (word_idx == WORDS-1); go to SEND.
- SEND:
  - Hold out_data, out_valid and out_last stable while out_ready == 0, for any number of cycles.
  - On out_valid && out_ready: out_valid <= 0 and out_last <= 0.
  - If word_idx == WORDS-1, go to RELEASE; otherwise word_idx <= word_idx+1 and go to FETCH.
- RELEASE:
  - release_valid = 1 and release_hash = hash, both held until release_ack.
  - On release_ack, release_valid <= 0 and go to IDLE.
  - release_ack outside RELEASE is ignored.
- Latency and throughput:
  - pit_in_bit accepted at edge E0: mem_rd_en is high in the cycle after E0, and out_valid rises at E2.
  - With out_ready held 1, one word per 3 cycles; 384 cycles of streaming per block.
- Busy collisions: pit_in_bit with [63]&[62] set while not in IDLE gives dropped = 1 for the next cycle only. The entry is not queued and the current transfer is unaffected.
- Simultaneous events: an entry arriving in the same cycle release_ack returns the block to IDLE is dropped (state is still RELEASE).
- word_idx is 7 bits and never wraps within a block.

Test Plan:
- Entry 0xC000_0000_0000_0400, hash 0x005, out_ready=1 -> mem_rd_addr steps 0x400, 0x408, … 0x7F8. 128 words in order; out_last only on word 128. Then release_valid with release_hash 0x005 until ack; busy returns to 0.
- Backpressure: out_ready=0 for 10 cycles on word 3 -> out_data, out_valid and out_last stable throughout; no extra mem_rd_en; stream resumes with word 4.
- Second valid pending entry during streaming -> exactly one-cycle dropped pulse; first block completes unaltered. Entries with [62]=0 or [63]=0 in IDLE -> no activity, no dropped pulse.
- Base 0x3FFF_FFFF_FFFF_FE00 (near the top of the 62-bit space) -> address wraps to 0x000 after 0x3FFF_FFFF_FFFF_FFF8; all 128 words read.
- rst=0 asserted at word 50 -> all outputs 0 after the edge, no release_valid; a new entry after reset streams from word 0.
- release_ack delayed 5 cycles -> release_valid and release_hash held; release_ack pulses in IDLE have no effect.

Source files
------------

// File: rtl/pit_data_reader.sv
// PIT hit reader: on a Data-packet hit, fetches the entry's buffer block word by
// word, streams it to the egress face and then asks the PIT to clear the slot.
module pit_data_reader #(
    parameter int ADDR_W      = 62,
    parameter int MEM_W       = 64,
    parameter int BLOCK_BYTES = 1024,
    parameter int WORDS       = BLOCK_BYTES * 8 / MEM_W,
    parameter int HASH_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       table_entry,
    input  logic              pit_in_bit,
    input  logic [HASH_W-1:0] entry_hash,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [MEM_W-1:0]  mem_rd_data,
    output logic [MEM_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              release_valid,
    output logic [HASH_W-1:0] release_hash,
    input  logic              release_ack,
    output logic              busy,
    output logic              dropped,
    output logic [2:0]        state_dbg
);

    // Handshakes: a word moves on out_valid && out_ready, and the release is
    // taken on release_valid && release_ack; neither valid ever drops or
    // changes its payload before the matching ready/ack has been seen.

    localparam int IDX_W  = $clog2(WORDS);
    localparam int OFF_SH = $clog2(MEM_W / 8);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [HASH_W-1:0] hash_q;
    logic [IDX_W-1:0]  word_idx;
    logic              entry_hit;
    logic              last_word;

    // Only a valid entry with a pending interest carries data to forward.
    assign entry_hit = pit_in_bit && table_entry[63] && table_entry[62];
    assign last_word = (word_idx == IDX_W'(WORDS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (entry_hit) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = last_word ? RELEASE : FETCH;
            RELEASE: if (release_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en     = 1'b0;
        mem_rd_addr   = '0;
        release_valid = 1'b0;
        release_hash  = '0;
        if (state == FETCH) begin
            mem_rd_en   = 1'b1;
            // Address arithmetic wraps modulo 2^ADDR_W by construction.
            mem_rd_addr = base_q + (ADDR_W'(word_idx) << OFF_SH);
        end
        if (state == RELEASE) begin
            release_valid = 1'b1;
            release_hash  = hash_q;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            base_q    <= '0;
            hash_q    <= '0;
            word_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state   <= state_nxt;
            // A hit that arrives while a block is in progress is lost, not queued.
            dropped <= entry_hit && (state != IDLE);
            case (state)
                IDLE: begin
                    if (entry_hit) begin
                        base_q   <= table_entry[ADDR_W-1:0];
                        hash_q   <= entry_hash;
                        word_idx <= '0;
                    end
                end
                CAPTURE: begin
                    out_data  <= mem_rd_data;
                    out_valid <= 1'b1;
                    out_last  <= last_word;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!last_word) word_idx <= word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pit_data_reader.sv
// Bench for pit_data_reader: directed block transfers with random bases, data
// and backpressure, checked against a queue model of the expected word stream.
module tb_pit_data_reader;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] table_entry;
    logic        pit_in_bit;
    logic [9:0]  entry_hash;
    logic        mem_rd_en;
    logic [61:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        release_valid;
    logic [9:0]  release_hash;
    logic        release_ack;
    logic        busy;
    logic        dropped;
    logic [2:0]  state_dbg;

    pit_data_reader dut (
        .clk          (clk),
        .rst          (rst),
        .table_entry  (table_entry),
        .pit_in_bit   (pit_in_bit),
        .entry_hash   (entry_hash),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .release_valid(release_valid),
        .release_hash (release_hash),
        .release_ack  (release_ack),
        .busy         (busy),
        .dropped      (dropped),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          n_total;
    int          n_pass;
    int          n_fail;
    int          out_cnt;
    int          last_cnt;
    int          cyc;
    logic [31:0] seed;
    logic [61:0] rb;
    logic [61:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    logic        prev_stall;
    logic [63:0] held_data_m;
    logic        held_last_m;

    // Buffer memory: contents are a seeded function of the byte address.
    function automatic logic [63:0] mem_word(input logic [61:0] a, input logic [31:0] s);
        return {a[31:0] ^ s, a[61:30] ^ ~s};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr, seed);
        else           mem_rd_data <= {$urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: block = 128 consecutive 8-byte words from base, mod 2^62
    task automatic load_model(input logic [61:0] b);
        exp_addr_q.delete();
        exp_data_q.delete();
        out_cnt    = 0;
        last_cnt   = 0;
        prev_stall = 1'b0;
        seed       = $urandom;
        for (int i = 0; i < WORDS; i++) begin
            logic [61:0] a;
            a = b + 62'(i * 8);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a, seed));
        end
    endtask

    task automatic monitor();
        if (rst !== 1'b1) return;
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held_data_m);
            chk("hold_last", out_last, held_last_m);
        end
        prev_stall  = out_valid && !out_ready;
        held_data_m = out_data;
        held_last_m = out_last;
        if (mem_rd_en) begin
            if (exp_addr_q.size() == 0) chk("rd_extra", mem_rd_en, 0);
            else                        chk("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
        end
        if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) chk("word_extra", out_valid, 0);
            else begin
                chk("out_data", out_data, exp_data_q.pop_front());
                chk("out_last", out_last, out_cnt == WORDS - 1);
            end
            out_cnt++;
            if (out_last) last_cnt++;
        end
    endtask

    // One cycle: sample at the falling edge, then return 1 time unit after the rise.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [61:0] b, input logic [9:0] h, input bit rnd,
                             input int stall_at, input int drop_at, input int ack_delay,
                             input bit sim_entry);
        logic [63:0] hd;
        logic        hl;
        bit          stalled;
        bit          drop_done;
        int          c;
        stalled   = 0;
        drop_done = 0;
        load_model(b);
        out_ready   = 1'b1;
        table_entry = {2'b11, b};
        entry_hash  = h;
        pit_in_bit  = 1'b1;
        step();
        pit_in_bit  = 1'b0;
        table_entry = {$urandom, $urandom};
        chk("lat_rd_en", mem_rd_en, 1);
        chk("first_addr", mem_rd_addr, b);
        chk("busy_on", busy, 1);
        step();
        chk("capture_no_valid", out_valid, 0);
        step();
        chk("valid_at_e2", out_valid, 1);
        c = 0;
        while (release_valid !== 1'b1 && c < 4000) begin
            c++;
            if (stall_at >= 0 && !stalled && out_cnt == stall_at && out_valid) begin
                out_ready = 1'b0;
                hd = out_data;
                hl = out_last;
                repeat (10) begin
                    step();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, hd);
                    chk("stall_last", out_last, hl);
                    chk("stall_no_rd", mem_rd_en, 0);
                end
                out_ready = 1'b1;
                stalled   = 1;
            end else if (drop_at >= 0 && !drop_done && out_cnt == drop_at) begin
                table_entry = {2'b11, 30'($urandom), $urandom};
                entry_hash  = 10'($urandom);
                pit_in_bit  = 1'b1;
                step();
                pit_in_bit = 1'b0;
                chk("drop_pulse", dropped, 1);
                step();
                chk("drop_once", dropped, 0);
                drop_done = 1;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                step();
            end
        end
        chk("release_reached", release_valid, 1);
        out_ready = 1'b1;
        repeat (ack_delay) begin
            chk("rel_hold_valid", release_valid, 1);
            chk("rel_hash", release_hash, h);
            step();
        end
        chk("rel_hash_ack", release_hash, h);
        release_ack = 1'b1;
        if (sim_entry) begin
            table_entry = {2'b11, 30'($urandom), $urandom};
            entry_hash  = 10'($urandom);
            pit_in_bit  = 1'b1;
        end
        step();
        release_ack = 1'b0;
        pit_in_bit  = 1'b0;
        chk("rel_clear", release_valid, 0);
        chk("idle_busy", busy, 0);
        chk("sim_drop", dropped, sim_entry);
        step();
        chk("no_restart", mem_rd_en, 0);
        chk("still_idle", busy, 0);
        chk("drop_cleared", dropped, 0);
        chk("word_count", out_cnt, WORDS);
        chk("last_count", last_cnt, 1);
        chk("addr_q_empty", exp_addr_q.size(), 0);
        chk("data_q_empty", exp_data_q.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_rel_valid", release_valid, 0);
        chk("rst_rel_hash", release_hash, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dropped", dropped, 0);
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        out_cnt = 0; last_cnt = 0; prev_stall = 1'b0;
        held_data_m = '0; held_last_m = 1'b0; seed = '0;
        rst = 1'b0; pit_in_bit = 1'b0; table_entry = '0; entry_hash = '0;
        out_ready = 1'b0; release_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        step();

        // Misses and interest allocations are ignored without a drop pulse.
        for (int p = 0; p < 3; p++) begin
            table_entry = {2'(p), 62'h400};
            entry_hash  = 10'($urandom);
            pit_in_bit  = 1'b1;
            step();
            pit_in_bit = 1'b0;
            chk("miss_busy", busy, 0);
            chk("miss_dropped", dropped, 0);
            chk("miss_rd_en", mem_rd_en, 0);
        end

        run_block(62'h400, 10'h005, 0, -1, -1, 5, 0);

        release_ack = 1'b1;
        repeat (3) begin
            step();
            chk("ack_idle_busy", busy, 0);
            chk("ack_idle_rel", release_valid, 0);
        end
        release_ack = 1'b0;

        run_block(62'({$urandom, $urandom}), 10'($urandom), 0, 3, 20, 0, 1);
        run_block(62'h3FFF_FFFF_FFFF_FE00, 10'($urandom), 1, -1, -1, 2, 0);

        // Reset in the middle of a block.
        rb = 62'({$urandom, $urandom});
        load_model(rb);
        out_ready   = 1'b1;
        table_entry = {2'b11, rb};
        entry_hash  = 10'($urandom);
        pit_in_bit  = 1'b1;
        step();
        pit_in_bit = 1'b0;
        cyc = 0;
        while (out_cnt < 50 && cyc < 1000) begin
            cyc++;
            step();
        end
        chk("reached_word50", out_cnt, 50);
        rst = 1'b0;
        step();
        chk_reset_outputs();
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        prev_stall = 1'b0;
        repeat (5) begin
            step();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_rel", release_valid, 0);
            chk("post_rst_rd", mem_rd_en, 0);
        end

        run_block(62'({$urandom, $urandom}), 10'($urandom), 1, -1, -1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
